instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 149 ++++++++++++++
 tb/tb_instr_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Serial program loader feeding a small instruction memory to a CPU.
// Words arrive MSB-first on ser_in, are written in order, then served by PC in RUN.
module instr_loader #(
    parameter int DEPTH = 32,
    parameter int IW    = 9,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(IW + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_mode,
    input  logic          ser_in,
    input  logic          ser_valid,
    input  logic [8:0]    pc,
    output logic [IW-1:0] instruction,
    output logic          instr_valid,
    output logic          cpu_hold,
    output logic [AW:0]   load_count,
    output logic          load_full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [9:0]    DEPTH_PC   = 10'(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_BIT   = CW'(IW - 1);

    state_t        state_reg;
    logic [IW-1:0] shift_reg;
    logic [IW-1:0] shift_next;
    logic [CW-1:0] bit_cnt_reg;
    logic [AW:0]   wr_addr_reg;
    logic [AW:0]   load_count_reg;
    logic [AW:0]   count_inc;
    logic          load_full_reg;
    logic [IW-1:0] instruction_reg;
    logic          instr_valid_reg;
    logic          cpu_hold_reg;

    logic [IW-1:0] mem [DEPTH];
    logic          wr_en;
    logic          pc_in_range;

    // Earlier bits migrate toward the MSB; the new bit lands in bit 0.
    assign shift_next[0] = ser_in;
    generate
        for (genvar gi = 1; gi < IW; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi-1];
        end
    endgenerate

    assign count_inc   = load_count_reg + 1'b1;
    assign pc_in_range = ({1'b0, pc} < DEPTH_PC);

    // A word caught by reset during WRITE must not reach memory.
    assign wr_en = (state_reg == WRITE) && !load_full_reg && !reset;

    // Memory has no reset so loaded programs survive a CPU reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_reg[AW-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            wr_addr_reg     <= '0;
            load_count_reg  <= '0;
            load_full_reg   <= 1'b0;
            instruction_reg <= '0;
            instr_valid_reg <= 1'b0;
            cpu_hold_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_mode) begin
                        state_reg      <= SHIFT;
                        bit_cnt_reg    <= '0;
                        wr_addr_reg    <= '0;
                        load_count_reg <= '0;
                        load_full_reg  <= 1'b0;
                    end else begin
                        state_reg <= RUN;
                    end
                end

                SHIFT: begin
                    if (!load_mode) begin
                        // Any partially shifted word is abandoned here.
                        state_reg   <= RUN;
                        bit_cnt_reg <= '0;
                    end else if (ser_valid) begin
                        shift_reg   <= shift_next;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (!load_full_reg) begin
                        wr_addr_reg    <= wr_addr_reg + 1'b1;
                        load_count_reg <= count_inc;
                        load_full_reg  <= (count_inc == DEPTH_CNT);
                    end
                    bit_cnt_reg <= '0;
                    state_reg   <= SHIFT;
                end

                RUN: begin
                    if (load_mode) begin
                        // Instruction keeps its last value while reloading.
                        state_reg       <= SHIFT;
                        bit_cnt_reg     <= '0;
                        wr_addr_reg     <= '0;
                        load_count_reg  <= '0;
                        load_full_reg   <= 1'b0;
                        instr_valid_reg <= 1'b0;
                        cpu_hold_reg    <= 1'b1;
                    end else begin
                        instruction_reg <= pc_in_range ? mem[pc[AW-1:0]] : '0;
                        instr_valid_reg <= 1'b1;
                        cpu_hold_reg    <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign instruction = instruction_reg;
    assign instr_valid = instr_valid_reg;
    assign cpu_hold    = cpu_hold_reg;
    assign load_count  = load_count_reg;
    assign load_full   = load_full_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: behavioural model checked every cycle, directed
// scenarios with literal expectations, then a randomized soak.
module tb_instr_loader;

    localparam int DEPTH = 32;
    localparam int IW    = 9;
    localparam int AW    = 5;

    logic          clk;
    logic          reset;
    logic          load_mode;
    logic          ser_in;
    logic          ser_valid;
    logic [8:0]    pc;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic          cpu_hold;
    logic [AW:0]   load_count;
    logic          load_full;

    instr_loader #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_mode   (load_mode),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .cpu_hold    (cpu_hold),
        .load_count  (load_count),
        .load_full   (load_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases of the loader seen from outside: waiting, collecting bits,
    // committing a completed word, serving the CPU.
    localparam int P_WAIT = 0, P_BITS = 1, P_COMMIT = 2, P_SERVE = 3;

    int            m_phase;
    int            m_bits;
    logic [IW-1:0] m_word;
    int            m_count;
    bit            m_full;
    logic [IW-1:0] m_instr;
    bit            m_instr_known;
    bit            m_valid;
    logic [IW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            armed = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    end

    task automatic m_new_session();
        m_phase = P_BITS;
        m_bits  = 0;
        m_word  = '0;
        m_count = 0;
        m_full  = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_phase       = P_WAIT;
            m_bits        = 0;
            m_word        = '0;
            m_count       = 0;
            m_full        = 1'b0;
            m_instr       = '0;
            m_instr_known = 1'b1;
            m_valid       = 1'b0;
            armed         = 1'b1;
        end else if (m_phase == P_WAIT) begin
            if (load_mode) m_new_session();
            else           m_phase = P_SERVE;
        end else if (m_phase == P_BITS) begin
            if (!load_mode) begin
                m_phase = P_SERVE;
            end else if (ser_valid) begin
                m_word = {m_word[IW-2:0], ser_in};
                m_bits++;
                if (m_bits == IW) m_phase = P_COMMIT;
            end
        end else if (m_phase == P_COMMIT) begin
            if (!m_full) begin
                m_mem[m_count]   = m_word;
                m_known[m_count] = 1'b1;
                m_count++;
                if (m_count == DEPTH) m_full = 1'b1;
            end
            m_bits  = 0;
            m_word  = '0;
            m_phase = P_BITS;
        end else begin
            if (load_mode) begin
                m_new_session();
                m_valid = 1'b0;
            end else begin
                if (int'(pc) < DEPTH) begin
                    m_instr       = m_mem[int'(pc)];
                    m_instr_known = m_known[int'(pc)];
                end else begin
                    m_instr       = '0;
                    m_instr_known = 1'b1;
                end
                m_valid = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("model_valid", 32'(instr_valid), 32'(m_valid));
            check("model_hold",  32'(cpu_hold),    32'(!m_valid));
            check("model_count", 32'(load_count),  32'(m_count));
            check("model_full",  32'(load_full),   32'(m_full));
            if (m_instr_known) check("model_instr", 32'(instruction), 32'(m_instr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [IW-1:0] w, input int nbits, input bit toggle);
        for (int i = IW - 1; i >= IW - nbits; i--) begin
            ser_valid = 1'b1;
            ser_in    = w[i];
            step();
            if (toggle) begin
                ser_valid = 1'b0;
                ser_in    = 1'($urandom);
                step();
            end
        end
        ser_valid = 1'b0;
    endtask

    task automatic send_word(input logic [IW-1:0] w, input bit toggle);
        send_bits(w, IW, toggle);
        ser_valid = 1'($urandom);
        ser_in    = 1'($urandom);
        step();
        ser_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_instr"}, 32'(instruction), 32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_hold"},  32'(cpu_hold),    32'h1);
        check({tag, "_count"}, 32'(load_count),  32'h0);
        check({tag, "_full"},  32'(load_full),   32'h0);
    endtask

    task automatic read_pc(input logic [8:0] addr, input string tag, input logic [IW-1:0] exp);
        pc = addr;
        step();
        check(tag, 32'(instruction), 32'(exp));
    endtask

    logic [IW-1:0] words [40];

    initial begin
        reset     = 1'b1;
        load_mode = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        pc        = '0;
        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;

        // Two words, then serve PC=1.
        load_mode = 1'b1;
        step();
        send_word(9'h1A5, 1'b0);
        send_word(9'h003, 1'b0);
        load_mode = 1'b0;
        pc        = 9'd1;
        step();
        check("first_run_valid", 32'(instr_valid), 32'h0);
        check("first_run_hold",  32'(cpu_hold),    32'h1);
        step();
        check("two_words_instr", 32'(instruction), 32'h003);
        check("two_words_model", 32'(m_instr),     32'h003);
        check("two_words_valid", 32'(instr_valid), 32'h1);
        check("two_words_hold",  32'(cpu_hold),    32'h0);
        check("two_words_count", 32'(load_count),  32'd2);
        read_pc(9'd0, "two_words_pc0", 9'h1A5);

        // Gappy ser_valid while loading 0x0FF.
        load_mode = 1'b1;
        step();
        check("reload_valid_drop", 32'(instr_valid), 32'h0);
        check("reload_instr_hold", 32'(instruction), 32'h1A5);
        send_word(9'h0FF, 1'b1);
        load_mode = 1'b0;
        step();
        read_pc(9'd0, "gappy_word", 9'h0FF);
        check("gappy_count", 32'(load_count), 32'd1);

        // Forty words: only the first 32 stick.
        for (int i = 0; i < 40; i++) words[i] = IW'($urandom);
        load_mode = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            send_word(words[i], 1'b0);
            if (i == 30) check("fill31_full", 32'(load_full), 32'h0);
            if (i == 31) begin
                check("fill32_full",  32'(load_full),  32'h1);
                check("fill32_count", 32'(load_count), 32'd32);
            end
        end
        check("fill40_count", 32'(load_count), 32'd32);
        check("fill40_full",  32'(load_full),  32'h1);
        load_mode = 1'b0;
        step();
        read_pc(9'd0,  "fill_mem0",  words[0]);
        read_pc(9'd31, "fill_mem31", words[31]);
        check("fill_hold_count", 32'(load_count), 32'd32);

        // Abort inside the third word.
        load_mode = 1'b1;
        step();
        send_word(9'h155, 1'b0);
        send_word(9'h0AA, 1'b0);
        send_bits(9'h1FF, 4, 1'b0);
        load_mode = 1'b0;
        step();
        check("abort_count", 32'(load_count), 32'd2);
        read_pc(9'd2, "abort_mem2", words[2]);
        read_pc(9'd0, "abort_mem0", 9'h155);

        // Out-of-range PC gives a NOP.
        read_pc(9'h040, "pc_out_of_range", 9'h000);
        read_pc(9'd32,  "pc_depth",        9'h000);

        // Reset mid-word, then reset during WRITE.
        load_mode = 1'b1;
        step();
        send_word(9'h0C3, 1'b0);
        send_bits(9'h0F0, 4, 1'b0);
        reset = 1'b1;
        step();
        check_reset_values("rst_midword");
        reset = 1'b0;
        step();
        send_bits(9'h1E1, IW, 1'b0);
        reset = 1'b1;
        step();
        check_reset_values("rst_write");
        reset     = 1'b0;
        load_mode = 1'b0;
        step();
        read_pc(9'd0, "survive_mem0", 9'h0C3);
        read_pc(9'd1, "survive_mem1", 9'h0AA);
        read_pc(9'd2, "survive_mem2", words[2]);

        // Randomized soak against the model.
        for (int seg = 0; seg < 6; seg++) begin
            int flip_odds;
            flip_odds = (seg % 2 == 0) ? 40 : 400;
            for (int c = 0; c < 1500; c++) begin
                reset     = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, flip_odds - 1) == 0) load_mode = ~load_mode;
                ser_valid = ($urandom_range(0, 3) != 0);
                ser_in    = 1'($urandom);
                pc        = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511))
                                                        : 9'($urandom_range(0, DEPTH + 3));
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
